bsg_demux_one_hot_buffered: RTL and testbench

Distribution-side counterpart to the one-hot mux: takes one ready/valid input stream tagged with a one-hot destination select and steers each word into one of `els_p` output channels. Each output channel has a two-entry buffer, so every channel independently sustains one word per cycle under back-pressure. It sits between a single producer and `els_p` consumers, such as response fan-out to per-requester queues.

---
 rtl/bsg_demux_one_hot_pkg.sv | 24 ++
 rtl/bsg_demux_one_hot_buffered_fifo2.sv | 67 ++++++
 rtl/bsg_demux_one_hot_buffered.sv | 95 +++++++++
 tb/tb_bsg_demux_one_hot_buffered.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_demux_one_hot_pkg.sv
// Shared types and constants for the buffered one-hot demux and its per-channel FIFO.
package bsg_demux_one_hot_pkg;

    localparam int unsigned fifo_depth_lp = 2;

    // Occupancy of one channel buffer, 0..fifo_depth_lp
    typedef logic [1:0] fifo_count_t;

    typedef enum logic [1:0] {
        sel_none  = 2'd0,
        sel_one   = 2'd1,
        sel_multi = 2'd2
    } sel_class_e;

    function automatic sel_class_e classify_sel(input int unsigned ones);
        if (ones == 0) begin
            return sel_none;
        end else if (ones == 1) begin
            return sel_one;
        end
        return sel_multi;
    endfunction

endpackage

// File: rtl/bsg_demux_one_hot_buffered_fifo2.sv
// Two-entry FIFO used as the per-channel output buffer; storage is not reset.
module bsg_demux_one_hot_buffered_fifo2
    import bsg_demux_one_hot_pkg::*;
#(
    parameter int unsigned width_p = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [width_p-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               valid,
    output logic [width_p-1:0] head_data
);

    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    fifo_count_t        count_q, count_d;
    logic [width_p-1:0] mem_q [fifo_depth_lp];
    logic               push_ok;
    logic               pop_ok;

    assign full      = (count_q == fifo_count_t'(fifo_depth_lp));
    assign valid     = (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];

    // Guard both sides so an overflow push or an empty pop never moves state
    assign push_ok = push & ~full;
    assign pop_ok  = pop & valid;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bsg_demux_one_hot_buffered.sv
// One-hot steered demux with a 2-entry buffer per output channel.
// Define BSG_DEMUX_ONE_HOT_BROADCAST_EN to treat multi-hot selects as broadcasts.
module bsg_demux_one_hot_buffered
    import bsg_demux_one_hot_pkg::*;
#(
    parameter int unsigned width_p = 9,
    parameter int unsigned els_p   = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [els_p-1:0]           sel_one_hot_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_o,
    output logic [els_p-1:0]           v_o,
    output logic [els_p*width_p-1:0]   data_o,
    input  logic [els_p-1:0]           yumi_i,
    output logic                       err_o
);

    int unsigned        sel_ones;
    sel_class_e         sel_class;
    logic               sel_legal;
    logic               sel_blocked;
    logic [els_p-1:0]   full;
    logic [els_p-1:0]   push;
    logic               err_q, err_d;

    assign sel_ones  = $countones(sel_one_hot_i);
    assign sel_class = classify_sel(sel_ones);

    // Blocked when any selected channel is full; uses registered state only
    assign sel_blocked = |(sel_one_hot_i & full);

    always_comb begin
        sel_legal = 1'b0;
        ready_o   = 1'b0;
        unique case (sel_class)
            sel_one: begin
                sel_legal = 1'b1;
                ready_o   = ~sel_blocked;
            end
            sel_multi: begin
`ifdef BSG_DEMUX_ONE_HOT_BROADCAST_EN
                sel_legal = 1'b1;
                ready_o   = ~sel_blocked;
`else
                sel_legal = 1'b0;
                ready_o   = 1'b1;
`endif
            end
            default: begin
                sel_legal = 1'b0;
                ready_o   = 1'b1;
            end
        endcase
        if (!reset_n_i) begin
            ready_o = 1'b0;
        end
    end

    assign push = {els_p{v_i & ready_o & sel_legal}} & sel_one_hot_i;

    assign err_d = err_q | (v_i & ready_o & ~sel_legal);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    for (genvar k = 0; k < els_p; k++) begin : g_chan
        logic [width_p-1:0] head;

        bsg_demux_one_hot_buffered_fifo2 #(
            .width_p(width_p)
        ) u_fifo (
            .clk       (clk_i),
            .reset_n   (reset_n_i),
            .push      (push[k]),
            .push_data (data_i),
            .pop       (yumi_i[k]),
            .full      (full[k]),
            .valid     (v_o[k]),
            .head_data (head)
        );

        assign data_o[k*width_p +: width_p] = head;
    end

endmodule

// File: tb/tb_bsg_demux_one_hot_buffered.sv
// Directed self-checking bench for bsg_demux_one_hot_buffered (3 channels, 9-bit data).
module tb_bsg_demux_one_hot_buffered;

    localparam int unsigned W = 9;
    localparam int unsigned N = 3;

    logic           clk;
    logic           reset_n;
    logic           v_i;
    logic [N-1:0]   sel;
    logic [W-1:0]   data_i;
    logic           ready;
    logic [N-1:0]   v_o;
    logic [N*W-1:0] data_o;
    logic [N-1:0]   yumi;
    logic           err;

    int total;
    int bad;

    bsg_demux_one_hot_buffered #(
        .width_p(W),
        .els_p  (N)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .v_i           (v_i),
        .sel_one_hot_i (sel),
        .data_i        (data_i),
        .ready_o       (ready),
        .v_o           (v_o),
        .data_o        (data_o),
        .yumi_i        (yumi),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] ch0, ch1, ch2;
    assign ch0 = data_o[W-1:0];
    assign ch1 = data_o[2*W-1:W];
    assign ch2 = data_o[3*W-1:2*W];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v_i    = 1'b0;
        sel    = '0;
        data_i = '0;
        yumi   = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        v_i     = 1'b1;
        sel     = 3'b001;
        data_i  = 9'h055;
        repeat (3) tick();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (v_o !== 3'b000) begin bad++; $display("FAIL reset_v_o got=%b want=000", v_o); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        reset_n = 1'b1;
        v_i     = 1'b0;
        tick();
        v_i = 1'b1;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", ready); end
        idle();
    endtask

    task automatic test_routing();
        v_i = 1'b1; sel = 3'b010; data_i = 9'h1A5;
        tick();
        idle();
        total++; if (v_o !== 3'b010) begin bad++; $display("FAIL route_v_o got=%b want=010", v_o); end
        total++; if (ch1 !== 9'h1A5) begin bad++; $display("FAIL route_data got=%h want=1a5", ch1); end
        yumi = 3'b010;
        tick();
        idle();
        total++; if (v_o !== 3'b000) begin bad++; $display("FAIL route_pop got=%b want=000", v_o); end
    endtask

    task automatic test_backpressure();
        v_i = 1'b1; sel = 3'b001; data_i = 9'h001;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready got=%b want=1", ready); end
        tick();
        data_i = 9'h002;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL bp_second_ready got=%b want=1", ready); end
        tick();
        data_i = 9'h003;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL bp_third_ready got=%b want=0", ready); end
        sel = 3'b100; data_i = 9'h0FF;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL bp_other_chan_ready got=%b want=1", ready); end
        tick();
        idle();
        total++; if (v_o !== 3'b101) begin bad++; $display("FAIL bp_v_o got=%b want=101", v_o); end
        total++; if (ch0 !== 9'h001) begin bad++; $display("FAIL bp_head0 got=%h want=001", ch0); end
        total++; if (ch2 !== 9'h0FF) begin bad++; $display("FAIL bp_head2 got=%h want=0ff", ch2); end
        yumi = 3'b001;
        tick();
        idle();
        total++; if (ch0 !== 9'h002) begin bad++; $display("FAIL bp_head0_after_pop got=%h want=002", ch0); end
        // Third word goes in while 002 is popped in the same cycle
        v_i = 1'b1; sel = 3'b001; data_i = 9'h003; yumi = 3'b001;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL bp_retry_ready got=%b want=1", ready); end
        tick();
        idle();
        total++; if (ch0 !== 9'h003) begin bad++; $display("FAIL bp_head0_third got=%h want=003", ch0); end
        total++; if (v_o !== 3'b101) begin bad++; $display("FAIL bp_v_o_third got=%b want=101", v_o); end
        yumi = 3'b101;
        tick();
        idle();
        total++; if (v_o !== 3'b000) begin bad++; $display("FAIL bp_drain got=%b want=000", v_o); end
    endtask

    task automatic test_full_pop();
        v_i = 1'b1; sel = 3'b010; data_i = 9'h0AA;
        tick();
        data_i = 9'h0BB;
        tick();
        data_i = 9'h0CC; yumi = 3'b010;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL fullpop_ready got=%b want=0", ready); end
        tick();
        idle();
        total++; if (v_o !== 3'b010) begin bad++; $display("FAIL fullpop_v_o got=%b want=010", v_o); end
        total++; if (ch1 !== 9'h0BB) begin bad++; $display("FAIL fullpop_head got=%h want=0bb", ch1); end
        yumi = 3'b010;
        tick();
        idle();
        total++; if (v_o !== 3'b000) begin bad++; $display("FAIL fullpop_count got=%b want=000", v_o); end
    endtask

    task automatic test_empty_yumi();
        yumi = 3'b111;
        tick();
        idle();
        total++; if (v_o !== 3'b000) begin bad++; $display("FAIL empty_yumi_v_o got=%b want=000", v_o); end
        v_i = 1'b1; sel = 3'b001; data_i = 9'h007;
        tick();
        idle();
        total++; if (v_o !== 3'b001) begin bad++; $display("FAIL empty_yumi_push got=%b want=001", v_o); end
        total++; if (ch0 !== 9'h007) begin bad++; $display("FAIL empty_yumi_data got=%h want=007", ch0); end
        yumi = 3'b001;
        tick();
        idle();
    endtask

    task automatic test_illegal();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_pre_err got=%b want=0", err); end
        v_i = 1'b1; sel = 3'b000; data_i = 9'h1FF;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL illegal_ready got=%b want=1", ready); end
        tick();
        idle();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b want=1", err); end
        total++; if (v_o !== 3'b000) begin bad++; $display("FAIL illegal_v_o got=%b want=000", v_o); end
        repeat (10) tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b want=1", err); end
    endtask

    task automatic test_broadcast();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bcast_reset_err got=%b want=0", err); end
        v_i = 1'b1; sel = 3'b101; data_i = 9'h155;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL bcast_ready got=%b want=1", ready); end
        tick();
        idle();
`ifdef BSG_DEMUX_ONE_HOT_BROADCAST_EN
        total++; if (v_o !== 3'b101) begin bad++; $display("FAIL bcast_v_o got=%b want=101", v_o); end
        total++; if (ch0 !== 9'h155) begin bad++; $display("FAIL bcast_ch0 got=%h want=155", ch0); end
        total++; if (ch2 !== 9'h155) begin bad++; $display("FAIL bcast_ch2 got=%h want=155", ch2); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bcast_err got=%b want=0", err); end
        yumi = 3'b101;
        tick();
        idle();
        v_i = 1'b1; sel = 3'b100; data_i = 9'h011;
        tick();
        data_i = 9'h022;
        tick();
        sel = 3'b101; data_i = 9'h155;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL bcast_full_ready got=%b want=0", ready); end
        tick();
        idle();
        total++; if (v_o !== 3'b100) begin bad++; $display("FAIL bcast_full_v_o got=%b want=100", v_o); end
        yumi = 3'b100;
        tick();
        tick();
        idle();
`else
        total++; if (v_o !== 3'b000) begin bad++; $display("FAIL multi_v_o got=%b want=000", v_o); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL multi_err got=%b want=1", err); end
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        idle();
        #2;
        test_reset();
        test_routing();
        test_backpressure();
        test_full_pop();
        test_empty_yumi();
        test_illegal();
        test_broadcast();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
